branch_train_queue: RTL and testbench

- Sits between the execute-stage branch resolution and the perceptron predictor's training port.
- Captures every resolved branch from EX together with the global history that preceded it, and buffers the records in a small FIFO.
- Drains records to the predictor over a valid/ready handshake, so the predictor can back-pressure training without stalling EX.
- Owns the architectural GHR and a saturating misprediction counter for performance monitoring.

---
 rtl/branch_train_queue.sv | 101 ++++++++++
 tb/tb_branch_train_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_train_queue.sv
// Training-record FIFO between EX branch resolution and the perceptron predictor.
// Also owns the architectural global history and a saturating mispredict counter.
module branch_train_queue #(
  parameter int DEPTH     = 4,
  parameter int HIST      = 28,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic                         in_taken,
  input  logic                         in_pred_taken,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic                         out_taken,
  output logic [HIST-1:0]              out_ghr,
  input  logic                         out_ready,
  output logic [HIST-1:0]              ghr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic                 taken_mem_q [DEPTH];
  logic [HIST-1:0]      ghr_mem_q   [DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [HIST-1:0]      ghr_q, ghr_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] mis_q, mis_d;
  logic                 enq, deq;

  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q != FULL) || out_ready;
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign out_pc         = pc_mem_q[rd_ptr_q];
  assign out_taken      = taken_mem_q[rd_ptr_q];
  assign out_ghr        = ghr_mem_q[rd_ptr_q];
  assign ghr            = ghr_q;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign mispredict_cnt = mis_q;

  always_comb begin
    wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // History advances on every resolved branch, accepted or dropped.
    ghr_d      = in_valid ? {ghr_q[HIST-2:0], in_taken} : ghr_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    mis_d      = mis_q;
    if (in_valid && (in_taken != in_pred_taken) && (mis_q != '1))
      mis_d = mis_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ghr_q      <= '0;
      overflow_q <= 1'b0;
      mis_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ghr_q      <= ghr_d;
      overflow_q <= overflow_d;
      mis_q      <= mis_d;
    end
  end

  // Snapshot is the history preceding this branch (pre-shift value).
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      taken_mem_q[wr_ptr_q] <= in_taken;
      ghr_mem_q[wr_ptr_q]   <= ghr_q;
    end
  end

endmodule

// File: tb/tb_branch_train_queue.sv
// Self-checking bench for branch_train_queue: directed table, corner sequences, random vs queue model.
module tb_branch_train_queue;
  localparam int DEPTH = 4;
  localparam int HIST  = 28;
  localparam int PW    = 32;
  localparam int CW    = 16;
  localparam int CWS   = 4;
  localparam int NC    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_taken = 1'b0, in_pred_taken = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] in_pc = '0;

  logic            in_ready, out_valid, out_taken, overflow;
  logic [PW-1:0]   out_pc;
  logic [HIST-1:0] out_ghr, ghr;
  logic [NC-1:0]   count;
  logic [CW-1:0]   mis_cnt;

  logic            s_in_ready, s_out_valid, s_out_taken, s_overflow;
  logic [PW-1:0]   s_out_pc;
  logic [HIST-1:0] s_out_ghr, s_ghr;
  logic [NC-1:0]   s_count;
  logic [CWS-1:0]  s_mis_cnt;

  always #5 clk = ~clk;

  branch_train_queue #(.DEPTH(DEPTH), .HIST(HIST), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_taken(in_taken),
    .in_pred_taken(in_pred_taken), .in_ready(in_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_taken(out_taken), .out_ghr(out_ghr), .out_ready(out_ready),
    .ghr(ghr), .count(count), .overflow(overflow), .mispredict_cnt(mis_cnt));

  // Narrow-counter instance shares the stimulus so saturation is reachable quickly.
  branch_train_queue #(.DEPTH(DEPTH), .HIST(HIST), .PC_WIDTH(PW), .CNT_WIDTH(CWS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_taken(in_taken),
    .in_pred_taken(in_pred_taken), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_pc(s_out_pc), .out_taken(s_out_taken), .out_ghr(s_out_ghr), .out_ready(out_ready),
    .ghr(s_ghr), .count(s_count), .overflow(s_overflow), .mispredict_cnt(s_mis_cnt));

  typedef struct {
    logic [PW-1:0]   pc;
    logic            t;
    logic [HIST-1:0] g;
  } rec_t;

  rec_t            mq[$];
  logic [HIST-1:0] m_ghr;
  bit              m_ovf;
  int              m_mis;
  int              nvec = 0;
  int              nerr = 0;

  typedef struct {
    logic            v;
    logic [PW-1:0]   pc;
    logic            t, p, ordy;
    int              e_count;
    logic            e_ov;
    logic [PW-1:0]   e_opc;
    logic [HIST-1:0] e_oghr, e_ghr;
    logic            e_ovf, e_irdy;
    int              e_mis;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ghr = '0;
    m_ovf = 1'b0;
    m_mis = 0;
  endtask

  task automatic model_step();
    bit   rdy;
    bit   dq;
    rec_t r;
    if (!rst) begin
      model_reset();
    end else begin
      rdy = (mq.size() != DEPTH) || out_ready;
      dq  = (mq.size() != 0) && out_ready;
      r   = '{in_pc, in_taken, m_ghr};
      if (dq) void'(mq.pop_front());
      if (in_valid && rdy) mq.push_back(r);
      if (in_valid && !rdy) m_ovf = 1'b1;
      if (in_valid) begin
        m_ghr = {m_ghr[HIST-2:0], in_taken};
        if (in_taken != in_pred_taken) m_mis++;
      end
    end
  endtask

  task automatic check_all();
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, (mq.size() != DEPTH) || out_ready);
    chk("ghr", ghr, m_ghr);
    chk("overflow", overflow, m_ovf);
    chk("mis_cnt", mis_cnt, (m_mis > 65535) ? 65535 : m_mis);
    chk("s_mis_cnt", s_mis_cnt, (m_mis > 15) ? 15 : m_mis);
    chk("s_count", s_count, mq.size());
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_taken", out_taken, mq[0].t);
      chk("out_ghr", out_ghr, mq[0].g);
    end
  endtask

  // Entered at posedge+1: drive, check the pre-edge state, clock, update the model.
  task automatic step(input logic v, input logic [PW-1:0] pc, input logic t,
                      input logic p, input logic ordy);
    in_valid = v; in_pc = pc; in_taken = t; in_pred_taken = p; out_ready = ordy;
    #1;
    check_all();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  logic [PW-1:0]   h_pc;
  logic            h_t;
  logic [HIST-1:0] h_g;

  initial begin
    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1, 1'b1, 32'h100, 28'h0,  28'h1,  1'b0, 1'b1, 0};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0,   28'h0,  28'h1,  1'b0, 1'b1, 0};
    tbl[2]  = '{1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'h200, 28'h1,  28'h3,  1'b0, 1'b1, 0};
    tbl[3]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h200, 28'h1,  28'h6,  1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h200, 28'h1,  28'hD,  1'b0, 1'b1, 1};
    tbl[5]  = '{1'b1, 32'h20C, 1'b1, 1'b1, 1'b0, 4, 1'b1, 32'h200, 28'h1,  28'h1B, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, 32'h210, 1'b0, 1'b0, 1'b0, 4, 1'b1, 32'h200, 28'h1,  28'h36, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 3, 1'b1, 32'h204, 28'h3,  28'h36, 1'b1, 1'b1, 1};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 2, 1'b1, 32'h208, 28'h6,  28'h36, 1'b1, 1'b1, 1};
    tbl[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1, 1'b1, 32'h20C, 28'hD,  28'h36, 1'b1, 1'b1, 1};
    tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0,   28'h0,  28'h36, 1'b1, 1'b1, 1};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    check_all();

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].t, tbl[i].p, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_ghr", i), ghr, tbl[i].e_ghr);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_irdy);
      chk($sformatf("tbl%0d_mis", i), mis_cnt, tbl[i].e_mis);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_opc);
        chk($sformatf("tbl%0d_out_ghr", i), out_ghr, tbl[i].e_oghr);
      end
    end

    // Full queue with a simultaneous dequeue accepts without overflow.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(4 * i), i[0], i[0], 1'b0);
    chk("full_count", count, 4);
    step(1'b1, 32'h310, 1'b1, 1'b1, 1'b1);
    chk("fulldeq_count", count, 4);
    chk("fulldeq_overflow", overflow, 1'b0);
    chk("fulldeq_out_pc", out_pc, 32'h304);

    // Head stays stable under back-pressure while new records arrive.
    do_reset();
    step(1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    h_pc = out_pc; h_t = out_taken; h_g = out_ghr;
    chk("stall_head_pc", h_pc, 32'h400);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h404 + 32'(4 * i), i[1], i[0], 1'b0);
      chk($sformatf("stall%0d_pc", i), out_pc, h_pc);
      chk($sformatf("stall%0d_taken", i), out_taken, h_t);
      chk($sformatf("stall%0d_ghr", i), out_ghr, h_g);
    end

    // Narrow counter saturates and holds; wide counter keeps counting.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
    chk("sat_small", s_mis_cnt, 4'hF);
    chk("sat_wide", mis_cnt, 16'd20);

    // Reset mid-operation discards everything, even with a branch arriving.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", count, 3);
    rst = 1'b0;
    step(1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_ghr", ghr, 28'h0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_mis", mis_cnt, 16'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      step(($urandom_range(0, 9) < 7), $urandom, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 3 : 8)));
    end
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
